// File: rtl/note_track_recorder_pkg.sv
// Shared types for the note track recorder: FSM state encoding.
// No logic; imported by the recorder top.
// No flow control of its own.
package note_track_recorder_pkg;

  // Recorder/player control states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REC     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/note_track_recorder_ram.sv
// Entry store: simple dual-port synchronous RAM, one write and one read port.
// Latency: read data appears one clock after re; write lands on the same edge.
// No backpressure; rdata holds its last value while re is low.
module note_track_recorder_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Unreset storage; the read register only updates on a requested read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/note_track_recorder.sv
// Multi-track run-length note recorder/player feeding the tone generator.
// Latency: playback entry valid 2 cycles after play_start, then 1 entry per 2 cycles.
// Backpressure: out_note/out_dur held while out_valid && !out_ready; play_abort ends playback.
module note_track_recorder
  import note_track_recorder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_TRACKS = 4,
  parameter int DUR_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_TRACKS)-1:0] track_sel,
  input  logic                          rec_en,
  input  logic                          tick,
  input  logic [DATA_WIDTH-1:0]         note_in,
  input  logic                          play_start,
  input  logic                          play_abort,
  input  logic                          clear_track,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_note,
  output logic [DUR_WIDTH-1:0]          out_dur,
  output logic                          play_done,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow
);

  localparam int TRK_W   = $clog2(NUM_TRACKS);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + DUR_WIDTH;
  localparam int RAM_AW  = TRK_W + ADDR_W;
  localparam logic [PTR_W-1:0]     DEPTH_P = PTR_W'(DEPTH);
  localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;

  state_t                state_q, state_d;
  logic [TRK_W-1:0]      trk_q;
  logic [PTR_W-1:0]      cnt_q [NUM_TRACKS];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] cur_note_q;
  logic [DUR_WIDTH-1:0]  dur_q;
  logic                  out_valid_q;
  logic                  overflow_q;

  logic [TRK_W-1:0]      act_trk;
  logic [PTR_W-1:0]      act_cnt;
  logic                  note_chg;
  logic                  commit;
  logic                  wr_en;
  logic                  accept;
  logic                  last_entry;
  logic [DUR_WIDTH-1:0]  dur_inc;
  logic [ENTRY_W-1:0]    rd_dat;

  // Active track is the latched one while a session runs, otherwise the selector.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    act_trk    = busy ? trk_q : track_sel;
    act_cnt    = cnt_q[act_trk];
    full       = (act_cnt == DEPTH_P);
    note_chg   = (note_in != cur_note_q);
    // A pending note is written when it ends, unless it never saw a tick.
    commit     = (state_q == ST_REC) && (dur_q != '0) && (!rec_en || note_chg);
    wr_en      = commit && !full;
    accept     = (state_q == ST_PRESENT) && out_valid_q && out_ready;
    last_entry = ((rd_ptr_q + PTR_W'(1)) == act_cnt);
    dur_inc    = (dur_q == DUR_MAX) ? dur_q : (dur_q + DUR_WIDTH'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; recording wins over clear, clear wins over play.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rec_en) begin
          state_d = ST_REC;
        end else if (clear_track) begin
          state_d = ST_IDLE;
        end else if (play_start) begin
          state_d = (cnt_q[track_sel] != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_REC: begin
        if (!rec_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = play_abort ? ST_DONE : ST_PRESENT;
      end
      ST_PRESENT: begin
        if (play_abort) begin
          state_d = ST_DONE;
        end else if (accept) begin
          state_d = last_entry ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: track counts, duration run-length counter, playback pointer, valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        cnt_q[i] <= '0;
      end
      trk_q       <= '0;
      rd_ptr_q    <= '0;
      cur_note_q  <= '0;
      dur_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rec_en) begin
            // A new recording rebuilds the track from address 0.
            trk_q            <= track_sel;
            cnt_q[track_sel] <= '0;
            cur_note_q       <= note_in;
            dur_q            <= '0;
          end else if (clear_track) begin
            cnt_q[track_sel] <= '0;
            overflow_q       <= 1'b0;
          end else if (play_start) begin
            trk_q    <= track_sel;
            rd_ptr_q <= '0;
          end
        end
        ST_REC: begin
          if (commit) begin
            if (full) begin
              overflow_q <= 1'b1;
            end else begin
              cnt_q[trk_q] <= cnt_q[trk_q] + PTR_W'(1);
            end
          end
          if (rec_en) begin
            if (note_chg) begin
              cur_note_q <= note_in;
              dur_q      <= tick ? DUR_WIDTH'(1) : '0;
            end else if (tick) begin
              dur_q <= dur_inc;
            end
          end
        end
        ST_FETCH: begin
          out_valid_q <= !play_abort;
        end
        ST_PRESENT: begin
          if (play_abort) begin
            out_valid_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b0;
            rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  note_track_recorder_ram #(
    .ADDR_W (RAM_AW),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({trk_q, cnt_q[trk_q][ADDR_W-1:0]}),
    .wdata ({cur_note_q, dur_q}),
    .re    (state_q == ST_FETCH),
    .raddr ({trk_q, rd_ptr_q[ADDR_W-1:0]}),
    .rdata (rd_dat)
  );

  // RAM read register is unreset, so outputs are masked to zero when not valid.
  always_comb begin
    out_valid = out_valid_q;
    out_note  = out_valid_q ? rd_dat[ENTRY_W-1 -: DATA_WIDTH] : '0;
    out_dur   = out_valid_q ? rd_dat[DUR_WIDTH-1:0] : '0;
    play_done = (state_q == ST_DONE);
    overflow  = overflow_q;
  end

endmodule
